// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded register file: default word width,
// default register count, and the data word type used by the design and its
// bench.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEF  = 19;  // default data word width in bits
  localparam int NREGS_DEF = 8;   // default architectural register count

  typedef logic [XLEN_DEF-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Tracks which architectural registers have a write-back outstanding.
//   - An issue reserves its destination (busy set) when accepted.
//   - A write-back releases its destination (busy cleared).
//   - Issue and write-back to the same register in one cycle: the set wins.
//   - Flush clears every reservation and blocks any concurrent issue.
//   - Register 0 never goes busy.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en_i, rd_addr_i    write-back valid and destination
//   iss_en_i, iss_addr_i  issue request and destination to reserve
//   flush_i               drop all reservations
//   busy_o                current busy vector (bit 0 is always 0)
//   iss_ready_o           issue accepted this cycle
//   busy_cnt_o            registered population count of the busy vector
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic             iss_en_i,
  input  logic [AW-1:0]    iss_addr_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_o,
  output logic             iss_ready_o,
  output logic [AW:0]      busy_cnt_o
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic [AW:0]      r_busy_cnt;
  logic [AW:0]      w_cnt_next;
  logic             w_wb_same;

  // A write-back landing on the issue destination this cycle frees it in time.
  assign w_wb_same = wr_en_i && (rd_addr_i == iss_addr_i);

  // Gated by reset_n so an issue is never reported accepted while in reset.
  assign iss_ready_o = reset_n && iss_en_i && !flush_i &&
                       ((iss_addr_i == '0) || !r_busy[iss_addr_i] || w_wb_same);

  // Priority, lowest to highest: hold, write-back clear, issue set, flush.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_busy_next = r_busy;
    if (wr_en_i) begin
      w_busy_next[rd_addr_i] = 1'b0;
    end
    if (iss_ready_o) begin
      w_busy_next[iss_addr_i] = 1'b1;
    end
    if (flush_i) begin
      w_busy_next = '0;
    end
    w_busy_next[0] = 1'b0;
  end

  // Count is taken from the next vector so busy_cnt_o tracks busy_o exactly.
  always_comb begin
    w_cnt_next = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_busy_next[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  assign busy_o     = r_busy;
  assign busy_cnt_o = r_busy_cnt;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with write-back bypass and a busy scoreboard for in-order
// issue. Register 0 reads as zero and is never reserved.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   rs_addr_i      NRD read addresses
//   rs_data_o      NRD read data (zero latency, write-back bypassed)
//   rs_busy_o      NRD pending-write flags for the read addresses
//   wr_en_i        write-back valid
//   rd_addr_i      write-back destination
//   wr_data_i      write-back data
//   iss_en_i       issue request
//   iss_addr_i     destination to reserve
//   iss_ready_o    issue accepted this cycle
//   flush_i        drop all reservations
//   busy_cnt_o     registered count of busy registers
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NRD-1:0][AW-1:0]    rs_addr_i,
  output logic [NRD-1:0][XLEN-1:0]  rs_data_o,
  output logic [NRD-1:0]            rs_busy_o,
  input  logic                      wr_en_i,
  input  logic [AW-1:0]             rd_addr_i,
  input  logic [XLEN-1:0]           wr_data_i,
  input  logic                      iss_en_i,
  input  logic [AW-1:0]             iss_addr_i,
  output logic                      iss_ready_o,
  input  logic                      flush_i,
  output logic [AW:0]               busy_cnt_o
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en_i     (wr_en_i),
    .rd_addr_i   (rd_addr_i),
    .iss_en_i    (iss_en_i),
    .iss_addr_i  (iss_addr_i),
    .flush_i     (flush_i),
    .busy_o      (w_busy),
    .iss_ready_o (iss_ready_o),
    .busy_cnt_o  (busy_cnt_o)
  );

  // Writes to register 0 are dropped, so its entry holds zero from reset on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this array is a handful of flops, not a RAM macro, so it can be
      // cleared by reset; a real SRAM would need a separate init sequence.
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en_i && (rd_addr_i != '0)) begin
      r_regs[rd_addr_i] <= wr_data_i;
    end
  end

  // Each read port is an identical copy; the bypass is gated by reset_n so
  // a write-back presented during reset cannot leak onto the read data.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic w_bypass;

    assign w_bypass = reset_n && wr_en_i && (rd_addr_i == rs_addr_i[k]) &&
                      (rs_addr_i[k] != '0);

    assign rs_data_o[k] = w_bypass ? wr_data_i : r_regs[rs_addr_i[k]];
    assign rs_busy_o[k] = !w_bypass && w_busy[rs_addr_i[k]];
  end

endmodule : regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter: XLEN, 19, data word width in bits.
REQ-002 SHALL have parameter: NREGS, 8, number of architectural registers, power of two, 2..32.
REQ-003 SHALL have parameter: NRD, 2, number of read ports, 1..4.
REQ-004 SHALL have derived localparam: AW, $clog2(NREGS), register address width.
REQ-005 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: rs_addr_i  input  NRD x AW  read addresses, one per port.
REQ-008 SHALL have port: rs_data_o  output  NRD x XLEN  read data, one per port.
REQ-009 SHALL have port: rs_busy_o  output  NRD  pending-write flag for each read address.
REQ-010 SHALL have port: wr_en_i  input  1  write-back valid.
REQ-011 SHALL have port: rd_addr_i  input  AW  write-back destination.
REQ-012 SHALL have port: wr_data_i  input  XLEN  write-back data.
REQ-013 SHALL have port: iss_en_i  input  1  issue request that reserves a destination.
REQ-014 SHALL have port: iss_addr_i  input  AW  destination to reserve.
REQ-015 SHALL have port: iss_ready_o  output  1  issue accepted this cycle.
REQ-016 SHALL have port: flush_i  input  1  drop all reservations.
REQ-017 SHALL have port: busy_cnt_o  output  AW+1  registered count of busy registers.

Function
REQ-018 SHALL hardwire register 0 to zero: writes to it are discarded, it never goes busy, and reads return 0 with busy 0.
REQ-019 SHALL write wr_data_i into register rd_addr_i (rd_addr_i != 0) on the clock edge at which wr_en_i=1, and clear that register's busy bit on the same edge.
REQ-020 SHALL return data combinationally on each read port with zero latency, with wr_data_i bypassed when wr_en_i=1, rd_addr_i=rs_addr_i[k] and the address is nonzero.
REQ-021 SHALL drive rs_busy_o[k] as busy[rs_addr_i[k]] and SHALL force it to 0 when the bypass of REQ-020 applies.
REQ-022 SHALL drive iss_ready_o = iss_en_i & (iss_addr_i==0 | ~busy[iss_addr_i] | (wr_en_i & rd_addr_i==iss_addr_i)) & ~flush_i.
REQ-023 SHALL set busy[iss_addr_i] on the edge at which iss_ready_o=1 and iss_addr_i != 0.
REQ-024 SHALL let the set win when an issue and a write-back target the same register in one cycle: data is written and busy ends at 1.
REQ-025 SHALL clear every busy bit on the next edge when flush_i=1, with flush overriding any issue; register data SHALL still be written by a concurrent write-back.
REQ-026 SHALL accept a write-back to a non-busy register (data updated, busy stays 0).
REQ-027 SHALL update busy_cnt_o on each edge to the population count of the next busy vector; it SHALL never exceed NREGS-1 and SHALL read 0 one cycle after a flush.
REQ-028 SHALL give all read ports independent, identical behaviour, including when ports share an address.

Reset
REQ-029 SHALL asynchronously clear all registers to 0, all busy bits to 0 and busy_cnt_o to 0 while reset_n=0, including mid-operation.
REQ-030 SHALL keep combinational outputs consistent with the cleared state during reset: rs_data_o=0, rs_busy_o=0 and iss_ready_o=0.
REQ-031 SHALL ignore all inputs until the first rising clk edge after reset_n deasserts.

Structure
REQ-032 SHALL place the XLEN and NREGS defaults and the typedef word_t = logic [XLEN-1:0] in package regfile_pkg.
REQ-033 SHALL implement the busy vector, issue/flush/write priority and busy counter in sub-module regfile_scoreboard, instantiated once.
REQ-034 SHALL keep the data array and bypass muxes in regfile_sb.

Verification
REQ-035 SHALL cover reset: after reset, read r1..r7 -> data 0, busy 0, busy_cnt_o=0.
REQ-036 SHALL cover bypass: write r3=19'h5A5A5 while reading r3 on both ports in the same cycle -> both ports return 19'h5A5A5 with busy 0; the next cycle also returns 19'h5A5A5.
REQ-037 SHALL cover a WAW stall: issue r4 -> busy_cnt_o=1; a second issue of r4 -> iss_ready_o=0; write-back of r4 plus issue of r4 in one cycle -> iss_ready_o=1, busy stays 1, busy_cnt_o=1.
REQ-038 SHALL cover flush: issue r1, r2 and r5 -> busy_cnt_o=3; assert flush with issue r6 -> iss_ready_o=0, next cycle busy_cnt_o=0 and all busy flags 0.
REQ-039 SHALL cover r0: write r0=19'h7FFFF and issue r0 -> reads of r0 return 0, busy 0, busy_cnt_o unchanged.
REQ-040 SHALL cover mid-operation reset: assert reset_n=0 between edges with r2 busy and data 19'h00123 -> outputs read 0 immediately without waiting for a clock edge.
